// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - start/complete handshake and result bus of the sequential divider
interface div_seq_if #(
  parameter int W = 4
);
  logic         init;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         done;
  logic         dz;

  // Requester side: issues operands, observes results
  modport master (
    output init, A, B,
    input  quo, rem, done, dz
  );

  // Divider side: accepts operands, produces results
  modport slave (
    input  init, A, B,
    output quo, rem, done, dz
  );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - restoring shift-subtract divider, one quotient bit per clock
module div_seq #(
  parameter int W = 4
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  // Trial subtract; the extra top bit carries the whole partial remainder so its sign is exact
  logic [W+1:0]  t_wide;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath: capture in IDLE, one shift-subtract step per RUN cycle
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    t_wide  = {r_q, q_q[W-1]} - {2'b00, d_q};

    case (state_q)
      S_IDLE: begin
        if (bus.init) begin
          if (bus.B != '0) begin
            r_d     = '0;
            q_d     = bus.A;
            d_d     = bus.B;
            cnt_d   = CW'(W);
            state_d = S_RUN;
          end else begin
            // Divide by zero short-circuits straight to completion
            quo_d   = '1;
            rem_d   = bus.A;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!t_wide[W+1]) begin
          r_d = t_wide[W:0];
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = {r_q[W-1:0], q_q[W-1]};
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = q_d;
          rem_d   = r_d[W-1:0];
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: results straight from their registers, done only while in DONE
  always_comb begin
    bus.quo  = quo_q;
    bus.rem  = rem_q;
    bus.dz   = dz_q;
    bus.done = (state_q == S_DONE);
  end

endmodule
